// File: rtl/mem_pkg.sv
// Shared encodings for the load/store path: access sizes, LSU states and
// word-alignment helpers.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Number of byte-offset bits below a word address.
  localparam int unsigned WORD_LSB = 2;

  typedef enum logic {
    IDLE,
    WRITE
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends sub-word load data, and
// merges sub-word store data into the word read back from memory.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = '0;
    half_v     = '0;
    load_data  = '0;
    merge_data = mem_rdata;

    case (lane)
      2'd0:    byte_v = mem_rdata[7:0];
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    half_v = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sext & byte_v[7]}}, byte_v};
        case (lane)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        load_data = {{16{sext & half_v[15]}}, half_v};
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      SIZE_WORD: begin
        load_data  = mem_rdata;
        merge_data = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only DataMem: sub-word loads with
// extension, read-modify-write sub-word stores, and a sticky fault register.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic              inclk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  input  logic              fault_clr,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              mem_cs,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       merge_q;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              misaligned;
  logic              fault_now;
  logic              access;
  logic              sub_store;

  lsu_lane_align u_lane_align (
    .size       (size),
    .sext       (sext),
    .lane       (addr[1:0]),
    .mem_rdata  (mem_rdata),
    .wdata      (wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    misaligned = ((size == SIZE_HALF) && addr[0]) ||
                 ((size == SIZE_WORD) && (addr[WORD_LSB-1:0] != '0));
    fault_now  = req && (state == IDLE) && !rst &&
                 ((size == SIZE_RSVD) || (ALIGN_CHECK && misaligned));
    access     = req && (state == IDLE) && !rst && !fault_now;
    sub_store  = access && we && (size != SIZE_WORD);
  end

  always_comb begin
    mem_cs    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
    mem_wdata = wdata;
    rdata     = '0;
    stall     = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (fault_now) begin
            done = 1'b1;
          end else if (access) begin
            mem_cs = 1'b1;
            if (!we) begin
              mem_rd = 1'b1;
              rdata  = load_data;
              done   = 1'b1;
            end else if (size == SIZE_WORD) begin
              mem_wr = 1'b1;
              done   = 1'b1;
            end else begin
              mem_rd = 1'b1;
              stall  = 1'b1;
            end
          end
        end
        WRITE: begin
          mem_cs    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = merge_q;
          done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      merge_q     <= '0;
      fault_valid <= 1'b0;
      fault_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sub_store) begin
            addr_q  <= {addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
            merge_q <= merge_data;
            state   <= WRITE;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase

      // A new fault outranks a simultaneous clear; otherwise the first
      // fault address is kept until cleared.
      if (fault_now) begin
        fault_valid <= 1'b1;
        if (!fault_valid || fault_clr) fault_addr <= addr;
      end else if (fault_clr) begin
        fault_valid <= 1'b0;
        fault_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts
// each access, a negedge monitor compares whenever the DUT signals done.
module tb_load_store_unit;

  logic        inclk = 1'b0;
  logic        rst;

  logic        req, we, sext, fault_clr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, fault_addr, mem_addr, mem_wdata, mem_rdata;
  logic        stall, done, fault_valid, mem_cs, mem_rd, mem_wr;

  logic        req_1, we_1, sext_1, fault_clr_1;
  logic [1:0]  size_1;
  logic [31:0] addr_1, wdata_1, rdata_1, fault_addr_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        stall_1, done_1, fault_valid_1, mem_cs_1, mem_rd_1, mem_wr_1;

  always #5 inclk = ~inclk;

  load_store_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut (
    .inclk(inclk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .fault_clr(fault_clr), .fault_valid(fault_valid), .fault_addr(fault_addr),
    .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) dut_noalign (
    .inclk(inclk), .rst(rst), .req(req_1), .we(we_1), .size(size_1), .sext(sext_1),
    .addr(addr_1), .wdata(wdata_1), .rdata(rdata_1), .stall(stall_1), .done(done_1),
    .fault_clr(fault_clr_1), .fault_valid(fault_valid_1), .fault_addr(fault_addr_1),
    .mem_cs(mem_cs_1), .mem_rd(mem_rd_1), .mem_wr(mem_wr_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
  );

  // Word-only data memories with combinational read
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  assign mem_rdata   = mem0[mem_addr[7:2]];
  assign mem_rdata_1 = mem1[mem_addr_1[7:2]];
  always @(posedge inclk) if (mem_cs && mem_wr) mem0[mem_addr[7:2]] <= mem_wdata;
  always @(posedge inclk) if (mem_cs_1 && mem_wr_1) mem1[mem_addr_1[7:2]] <= mem_wdata_1;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          cs, rd, wr;
    logic [31:0] wdat;
    logic [31:0] maddr;
    int          stalls;
    bit          fv;
    logic [31:0] fa;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  logic [31:0] ref_mem [64];
  bit          ref_fv;
  logic [31:0] ref_fa;
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completed access
  always @(negedge inclk) begin
    if (rst) begin
      stall_seen = 0;
    end else begin
      if (stall) stall_seen++;
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending access");
        end else begin
          m = sb.pop_front();
          if (m.chk_rdata) check("rdata", rdata, m.rdata);
          check("mem_cs", {31'b0, mem_cs}, {31'b0, m.cs});
          check("mem_rd", {31'b0, mem_rd}, {31'b0, m.rd});
          check("mem_wr", {31'b0, mem_wr}, {31'b0, m.wr});
          if (m.cs) check("mem_addr", mem_addr, m.maddr);
          if (m.wr) check("mem_wdata", mem_wdata, m.wdat);
          check("stall_cycles", stall_seen, m.stalls);
          check("fault_valid", {31'b0, fault_valid}, {31'b0, m.fv});
          check("fault_addr", fault_addr, m.fa);
        end
        stall_seen = 0;
      end
    end
  end

  // Entered and left at #1 after a rising edge.
  task automatic access(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd, input bit clr);
    exp_t        e;
    bit          flt;
    int unsigned idx, sh;
    logic [31:0] wv, v, mask;
    flt = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    idx = (a / 4) % 64;
    e.rdata = '0; e.chk_rdata = 0; e.cs = 0; e.rd = 0; e.wr = 0; e.wdat = '0;
    e.maddr = a & ~32'h3; e.stalls = 0; e.fv = ref_fv; e.fa = ref_fa;
    if (flt) begin
      e.chk_rdata = 1;
      if (!ref_fv || clr) ref_fa = a;
      ref_fv = 1;
    end else begin
      e.cs = 1;
      wv = ref_mem[idx];
      sh = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      if (!w) begin
        e.rd = 1; e.chk_rdata = 1;
        if (sz == 2'd2) v = wv;
        else begin
          v = (wv & mask) >> sh;
          if (sx && sz == 2'd0 && v >= 32'h80)   v = v | 32'hFFFFFF00;
          if (sx && sz == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        e.rdata = v;
      end else if (sz == 2'd2) begin
        e.wr = 1; e.wdat = wd; ref_mem[idx] = wd;
      end else begin
        e.wr = 1; e.stalls = 1;
        v = (wv & ~mask) | ((wd << sh) & mask);
        e.wdat = v; ref_mem[idx] = v;
        if (clr) begin e.fv = 0; e.fa = '0; end
      end
      if (clr) begin ref_fv = 0; ref_fa = '0; end
    end
    sb.push_back(e);
    req = 1; we = w; size = sz; sext = sx; addr = a; wdata = wd; fault_clr = clr;
    for (int n = 0; ; n++) begin
      @(negedge inclk);
      if (done) break;
      if (n >= 4) begin
        n_checks++; n_fail++;
        $display("FAIL access_timeout: got no done expected done within 5 cycles");
        break;
      end
    end
    @(posedge inclk); #1;
    req = 0; we = 0; size = 0; sext = 0; addr = 0; wdata = 0; fault_clr = 0;
  endtask

  task automatic peek_faults(input string name);
    @(negedge inclk);
    check({name, "_fv"}, {31'b0, fault_valid}, {31'b0, ref_fv});
    check({name, "_fa"}, fault_addr, ref_fa);
    @(posedge inclk); #1;
  endtask

  task automatic clear_fault();
    fault_clr = 1;
    @(posedge inclk); #1;
    fault_clr = 0;
    ref_fv = 0; ref_fa = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; req = 1; we = 0; size = 2'd2; sext = 0; addr = 32'h10; wdata = 0; fault_clr = 0;
    req_1 = 0; we_1 = 0; size_1 = 0; sext_1 = 0; addr_1 = 0; wdata_1 = 0; fault_clr_1 = 0;
    ref_fv = 0; ref_fa = '0;
    @(posedge inclk); #1;
    @(negedge inclk);
    check("rst_strobes", {29'b0, mem_cs, mem_rd, mem_wr}, 32'h0);
    check("rst_stall_done", {30'b0, stall, done}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge inclk); #1;
    rst = 0; req = 0; size = 0; addr = 0;
    @(negedge inclk);
    check("rst_fault_valid", {31'b0, fault_valid}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    check("idle_outputs", {28'b0, stall, done, mem_cs, mem_wr}, 32'h0);
    @(posedge inclk); #1;

    for (int i = 0; i < 64; i++) access(1, 2'd2, 0, i * 4, 32'h0, 0);

    // Load extension
    access(1, 2'd2, 0, 32'h10, 32'h88223344, 0);
    access(0, 2'd0, 1, 32'h13, 32'h0, 0);
    access(0, 2'd0, 0, 32'h13, 32'h0, 0);
    access(0, 2'd1, 0, 32'h10, 32'h0, 0);
    // Byte store read-modify-write
    access(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
    access(1, 2'd0, 0, 32'h11, 32'h000000AB, 0);
    access(0, 2'd2, 0, 32'h10, 32'h0, 0);
    // Word store then halfword accesses
    access(1, 2'd2, 0, 32'h14, 32'hDEADBEEF, 0);
    access(0, 2'd1, 0, 32'h16, 32'h0, 0);
    access(0, 2'd1, 1, 32'h16, 32'h0, 0);
    access(1, 2'd1, 0, 32'h14, 32'h00001234, 0);
    access(0, 2'd2, 0, 32'h14, 32'h0, 0);
    // Faults
    access(0, 2'd2, 0, 32'h12, 32'h0, 0);
    peek_faults("fault_first");
    access(1, 2'd1, 0, 32'h21, 32'h5555, 0);
    peek_faults("fault_sticky");
    clear_fault();
    peek_faults("fault_clear");
    access(0, 2'd3, 0, 32'h40, 32'h0, 0);
    peek_faults("fault_rsvd");

    // Reset during the write cycle of a byte store
    access(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
    req = 1; we = 1; size = 2'd0; addr = 32'h11; wdata = 32'hCD;
    @(negedge inclk);
    check("abort_cycle_a", {30'b0, stall, mem_rd}, 32'h3);
    @(posedge inclk); #1;
    rst = 1;
    @(negedge inclk);
    check("abort_no_write", {30'b0, mem_wr, done}, 32'h0);
    @(posedge inclk); #1;
    rst = 0; req = 0; we = 0; size = 0; addr = 0; wdata = 0;
    ref_fv = 0; ref_fa = '0;
    check("abort_mem", mem0[4], 32'h11223344);
    access(0, 2'd2, 0, 32'h10, 32'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             $urandom_range(0, 255), $urandom, ($urandom_range(0, 15) == 0));
    end
    peek_faults("random_end");
    for (int i = 0; i < 64; i++) begin
      access(0, 2'd2, 0, i * 4, 32'h0, 0);
      check("mem_contents", mem0[i], ref_mem[i]);
    end

    // Alignment checking disabled
    req_1 = 1; we_1 = 1; size_1 = 2'd2; addr_1 = 32'h10; wdata_1 = 32'h11223344;
    @(posedge inclk); #1;
    we_1 = 0; addr_1 = 32'h13; wdata_1 = 0;
    @(negedge inclk);
    check("na_lw_rdata", rdata_1, 32'h11223344);
    check("na_lw_strobes", {28'b0, stall_1, done_1, mem_cs_1, mem_rd_1}, 32'h7);
    check("na_lw_addr", mem_addr_1, 32'h10);
    @(posedge inclk); #1;
    req_1 = 0;
    @(negedge inclk);
    check("na_no_fault", {31'b0, fault_valid_1}, 32'h0);
    @(posedge inclk); #1;
    req_1 = 1; size_1 = 2'd3; addr_1 = 32'h40;
    @(negedge inclk);
    check("na_rsvd_done", {29'b0, done_1, mem_cs_1, mem_wr_1}, 32'h4);
    @(posedge inclk); #1;
    addr_1 = 32'h44;
    @(negedge inclk);
    check("na_fault_first", {fault_addr_1[30:0], fault_valid_1}, {31'h40, 1'b1});
    @(posedge inclk); #1;
    addr_1 = 32'h48; fault_clr_1 = 1;
    @(negedge inclk);
    check("na_fault_sticky", fault_addr_1, 32'h40);
    @(posedge inclk); #1;
    req_1 = 0; fault_clr_1 = 0;
    @(negedge inclk);
    check("na_clr_new_wins", {fault_addr_1[30:0], fault_valid_1}, {31'h48, 1'b1});
    @(posedge inclk); #1;

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath and DataMem; DataMem does word-only reads and writes.
- Adds byte and halfword loads with sign or zero extension.
- Adds byte and halfword stores as a two-cycle read-modify-write, stalling the CPU for one cycle.
- Detects misaligned and illegal accesses and records the first fault in a sticky register.

Parameters:
ADDR_W, 32, address width on both CPU and memory sides
ALIGN_CHECK, 1, 1: misaligned half/word raises a fault; 0: low address bits are truncated, no fault

Ports:
inclk  in  1  clock; memory write commits on this rising edge
rst  in  1  synchronous, active-high reset
req  in  1  CPU access request; held stable by the CPU while stall=1
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-aligned
rdata  out  32  load result, right-aligned and extended
stall  out  1  CPU must hold PC and request this cycle
done  out  1  access completes this cycle
fault_clr  in  1  clears the sticky fault
fault_valid  out  1  sticky fault flag
fault_addr  out  ADDR_W  address of first fault since clear
mem_cs  out  1  to DataMem CS
mem_rd  out  1  to DataMem DM_R
mem_wr  out  1  to DataMem DM_W
mem_addr  out  ADDR_W  always {addr[ADDR_W-1:2],2'b00}; in WRITE state it is the latched address
mem_wdata  out  32  to DataMem data_w
mem_rdata  in  32  from DataMem data_r (combinational read)

Behaviour:
- Little-endian lanes:
  - byte k = bits [8k+7:8k], selected by addr[1:0].
  - half = [15:0] when addr[1]=0, [31:16] when addr[1]=1.
- Fault conditions (evaluated only when req=1, state IDLE):
  - size=11 always faults.
  - With ALIGN_CHECK=1: half with addr[0]=1, or word with addr[1:0]!=0.
- States: IDLE, WRITE.
- IDLE, req=0: all strobes 0, rdata=0, stall=0, done=0.
- IDLE, load, no fault:
  - mem_cs=mem_rd=1.
  - rdata is the extracted lane in the same cycle; done=1, stall=0.
- IDLE, word store, no fault:
  - mem_cs=mem_wr=1, mem_wdata=wdata; commits at the edge.
  - done=1, stall=0.
- IDLE, byte/half store, no fault (cycle A):
  - mem_cs=mem_rd=1, stall=1, done=0.
  - At the edge, latch addr_q, and latch merge_q = mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0].
  - Next state is WRITE.
- WRITE (cycle B):
  - mem_cs=mem_wr=1, mem_addr=addr_q, mem_wdata=merge_q.
  - stall=0, done=1; next state is IDLE.
  - req, we, size and addr are ignored in this state.
- Fault:
  - No memory strobes, rdata=0, done=1, stall=0.
  - At the edge, fault_valid is set. fault_addr loads addr only if fault_valid was 0 (first fault preserved).
  - fault_clr with no new fault: fault_valid=0, fault_addr=0.
  - fault_clr and a new fault in the same cycle: the new fault wins; fault_valid=1, fault_addr=addr.
- Reset (rst=1):
  - All mem strobes are forced 0 combinationally in the reset cycle; stall=0, done=0, rdata=0.
  - At the edge: state=IDLE, merge_q=0, addr_q=0, fault_valid=0, fault_addr=0.
  - Reset during WRITE aborts the write; memory is unchanged.
- Latency: loads and word stores 1 cycle; sub-word stores 2 cycles (exactly one stall cycle).
- No back-to-back hazard: the next request is sampled only in IDLE.

Decomposition:
- Shared package mem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD encodings
  - lsu_state_t {IDLE, WRITE}
  - the word-alignment helper constant
- One combinational sub-module, lsu_lane_align, holds lane extraction with sign/zero extension and the store merge.
- The FSM and fault register stay in load_store_unit.

Test Plan:
1. Load extension: mem[0x10]=0x88223344.
   - lb 0x13 sext=1 -> rdata 0xFFFFFF88.
   - lbu 0x13 -> 0x00000088.
   - lh 0x10 -> 0x00003344.
   - Each gives done=1, stall=0 in the same cycle.
2. Byte store: mem[0x10]=0x11223344, sb 0x11 wdata 0x000000AB.
   - Cycle A: stall=1, mem_rd=1.
   - Cycle B: mem_wr=1, mem_wdata 0x1122AB44, done=1.
   - Follow-up lw 0x10 -> 0x1122AB44.
3. Word store then halfword loads: sw 0x14 0xDEADBEEF (single cycle, no stall).
   - lhu 0x16 -> 0x0000DEAD.
   - lh 0x16 -> 0xFFFFDEAD.
   - sh 0x14 0x1234 -> word 0xDEAD1234.
4. Faults: lw 0x12.
   - No strobes, done=1, fault_valid=1, fault_addr 0x12.
   - Then sh 0x21 -> fault_addr stays 0x12.
   - fault_clr with no request -> fault_valid 0.
   - size=11 at 0x40 -> faults.
5. Reset abort: sb 0x11 with rst=1 in cycle B.
   - mem_wr=0 that cycle; mem[0x10] is unchanged; state returns to IDLE.
   - Next lw gives done in 1 cycle.
6. ALIGN_CHECK=0: lw 0x13 reads word 0x10, no fault. Clear and set fault_clr in the same cycle as a new fault -> fault_valid=1, fault_addr = new address.
